// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter
//
// Two-master round-robin arbiter for port s2 of the shared dual-port RAM.
// Master 0 is the multiply sequencer. Master 1 is the status/result writer.
// Each clock, at most one request wins. The winning access is registered onto
// the dpram_s2_* pins. Read completions go back to the issuing master through
// a tag pipeline that is READ_LATENCY+1 stages deep.
//
// Optional feature, enabled by defining DPRAM_ARB_LOCK_EN: a master that
// handshakes with lock=1 keeps the port until it handshakes with lock=0. When
// the macro is undefined, the lock inputs are ignored and every handshake is
// arbitrated round-robin.
//
// Ports:
//   clk_i, rst_i_n           clock, async active-low reset
//   mN_req_i/we/addr/wdata   master N access request (N = 0, 1)
//   mN_lock_i                master N keeps ownership after this beat
//   mN_gnt_o                 combinational grant
//   mN_rvalid_o, mN_rdata_o  read completion pulse and data
//   dpram_s2_*               registered RAM port s2 controls, RAM read data in
module dpram_port_arbiter #(
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic              clk_i,
  input  logic              rst_i_n,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  input  logic              m0_lock_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  input  logic              m1_lock_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic [ADDR_W-1:0] dpram_s2_addr_o,
  output logic              dpram_s2_clken_o,
  output logic              dpram_s2_write_en_o,
  output logic [DATA_W-1:0] dpram_s2_writedata,
  input  logic [DATA_W-1:0] dpram_s2_readdata
);

  localparam int unsigned TagDepth = READ_LATENCY + 1;

  typedef enum logic [1:0] {ArbOpen, ArbLock0, ArbLock1} arb_state_e;

  arb_state_e state_q, state_d;
  // Id of the master that took the most recent handshake. It resets to 1 so
  // that master 0 wins the first contention.
  logic last_grant_q, last_grant_d;

  logic hs0, hs1, hs;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              clken_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [TagDepth-1:0] tag_valid_q;
  logic [TagDepth-1:0] tag_id_q;

  // State register
  always_ff @(posedge clk_i or negedge rst_i_n) begin
    if (!rst_i_n) begin
      state_q      <= ArbOpen;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    if (hs0) begin
      last_grant_d = 1'b0;
    end else if (hs1) begin
      last_grant_d = 1'b1;
    end
`ifdef DPRAM_ARB_LOCK_EN
    unique case (state_q)
      ArbOpen: begin
        if (hs0 && m0_lock_i) begin
          state_d = ArbLock0;
        end else if (hs1 && m1_lock_i) begin
          state_d = ArbLock1;
        end
      end
      ArbLock0: if (hs0 && !m0_lock_i) state_d = ArbOpen;
      ArbLock1: if (hs1 && !m1_lock_i) state_d = ArbOpen;
      default:  state_d = ArbOpen;
    endcase
`else
    state_d = ArbOpen;
`endif
  end

`ifndef DPRAM_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = m0_lock_i ^ m1_lock_i;
`endif

  // Output logic: grants are combinational and are held low while in reset
  always_comb begin
    m0_gnt_o = 1'b0;
    m1_gnt_o = 1'b0;
    if (rst_i_n) begin
      unique case (state_q)
        ArbLock0: m0_gnt_o = m0_req_i;
        ArbLock1: m1_gnt_o = m1_req_i;
        default: begin
          if (m0_req_i && m1_req_i) begin
            m0_gnt_o = last_grant_q;
            m1_gnt_o = ~last_grant_q;
          end else begin
            m0_gnt_o = m0_req_i;
            m1_gnt_o = m1_req_i;
          end
        end
      endcase
    end
  end

  assign hs0 = m0_req_i & m0_gnt_o;
  assign hs1 = m1_req_i & m1_gnt_o;
  assign hs  = hs0 | hs1;

  assign sel_we    = hs1 ? m1_we_i    : m0_we_i;
  assign sel_addr  = hs1 ? m1_addr_i  : m0_addr_i;
  assign sel_wdata = hs1 ? m1_wdata_i : m0_wdata_i;

  // Issue registers and read tag pipeline. Addr and wdata hold when idle.
  always_ff @(posedge clk_i or negedge rst_i_n) begin
    if (!rst_i_n) begin
      clken_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      tag_valid_q <= '0;
      tag_id_q    <= '0;
    end else begin
      clken_q     <= hs;
      we_q        <= hs & sel_we;
      if (hs) begin
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
      tag_valid_q <= {tag_valid_q[TagDepth-2:0], hs & ~sel_we};
      tag_id_q    <= {tag_id_q[TagDepth-2:0], hs1};
    end
  end

  assign dpram_s2_addr_o     = addr_q;
  assign dpram_s2_clken_o    = clken_q;
  assign dpram_s2_write_en_o = we_q;
  assign dpram_s2_writedata  = wdata_q;

  assign m0_rvalid_o = tag_valid_q[TagDepth-1] & ~tag_id_q[TagDepth-1];
  assign m1_rvalid_o = tag_valid_q[TagDepth-1] &  tag_id_q[TagDepth-1];
  assign m0_rdata_o  = dpram_s2_readdata;
  assign m1_rdata_o  = dpram_s2_readdata;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter. Three instances run side by side with
// READ_LATENCY = 1, 2 and 3. Each instance has its own RAM model of matching
// latency. The arbitration vectors are table-driven, and the read and issue
// traffic is checked against scoreboard queues.
module tb_dpram_port_arbiter;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned NI = 3;

  logic clk_i = 1'b0;
  logic rst_n;
  always #5 clk_i = ~clk_i;

  logic m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;

  logic          g0 [NI];
  logic          g1 [NI];
  logic          rv0 [NI];
  logic          rv1 [NI];
  logic [DW-1:0] rd0 [NI];
  logic [DW-1:0] rd1 [NI];
  logic [AW-1:0] s2_addr [NI];
  logic          s2_clken [NI];
  logic          s2_we [NI];
  logic [DW-1:0] s2_wdata [NI];
  logic [DW-1:0] s2_rdata [NI];

  logic ram_ready = 1'b0;
  logic mon_en = 1'b0;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  logic [DW-1:0] ref_mem [16];

  always @(posedge clk_i) cyc <= cyc + 1;

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int unsigned RL = gi + 1;
    logic [DW-1:0] mem [16];
    logic [DW-1:0] pipe [RL];

    dpram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)) u_dut (
      .clk_i(clk_i), .rst_i_n(rst_n),
      .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
      .m0_lock_i(m0_lock), .m0_gnt_o(g0[gi]), .m0_rvalid_o(rv0[gi]), .m0_rdata_o(rd0[gi]),
      .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
      .m1_lock_i(m1_lock), .m1_gnt_o(g1[gi]), .m1_rvalid_o(rv1[gi]), .m1_rdata_o(rd1[gi]),
      .dpram_s2_addr_o(s2_addr[gi]), .dpram_s2_clken_o(s2_clken[gi]),
      .dpram_s2_write_en_o(s2_we[gi]), .dpram_s2_writedata(s2_wdata[gi]),
      .dpram_s2_readdata(s2_rdata[gi])
    );

    // RAM model: the address is sampled on a clken edge, and the data
    // appears RL cycles after the clken cycle.
    always @(posedge clk_i) begin
      if (!ram_ready) begin
        for (int a = 0; a < 16; a++) mem[a] <= 32'hC0DE_0000 + a;
      end else if (s2_clken[gi]) begin
        if (s2_we[gi]) mem[s2_addr[gi]] <= s2_wdata[gi];
        pipe[0] <= mem[s2_addr[gi]];
      end
      for (int k = RL - 1; k > 0; k--) pipe[k] <= pipe[k-1];
    end
    assign s2_rdata[gi] = pipe[RL-1];
  end

  typedef struct {
    logic r0; logic w0; logic [AW-1:0] a0; logic [DW-1:0] d0; logic l0;
    logic r1; logic w1; logic [AW-1:0] a1; logic [DW-1:0] d1; logic l1;
    logic eg0; logic eg1;
  } vec_t;

  typedef struct { int due; logic id; logic [DW-1:0] data; } rd_exp_t;
  typedef struct { int due; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } is_exp_t;

  rd_exp_t q_rd0[$];
  rd_exp_t q_rd1[$];
  rd_exp_t q_rd2[$];
  is_exp_t q_is[$];
  vec_t    vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(logic r0, logic w0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                              logic l0, logic r1, logic w1, logic [AW-1:0] a1,
                              logic [DW-1:0] d1, logic l1, logic eg0, logic eg1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.l0 = l0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.l1 = l1;
    v.eg0 = eg0; v.eg1 = eg1;
    return v;
  endfunction

  // An expected handshake in cycle cyc issues in cyc+1 and returns in cyc+1+RL
  task automatic issue(input logic id, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    is_exp_t ie;
    rd_exp_t re;
    ie.due = cyc + 1; ie.we = we; ie.addr = a; ie.wdata = d;
    q_is.push_back(ie);
    if (we) begin
      ref_mem[a] = d;
    end else begin
      re.id = id; re.data = ref_mem[a];
      re.due = cyc + 2; q_rd0.push_back(re);
      re.due = cyc + 3; q_rd1.push_back(re);
      re.due = cyc + 4; q_rd2.push_back(re);
    end
  endtask

  // Called at posedge+1: drive, check grants mid-cycle, and take the edge
  task automatic beat(input vec_t v);
    m0_req = v.r0; m0_we = v.w0; m0_addr = v.a0; m0_wdata = v.d0; m0_lock = v.l0;
    m1_req = v.r1; m1_we = v.w1; m1_addr = v.a1; m1_wdata = v.d1; m1_lock = v.l1;
    @(negedge clk_i);
    for (int i = 0; i < int'(NI); i++) begin
      chk($sformatf("L%0d gnt {m1,m0}", i + 1), {g1[i], g0[i]}, {v.eg1, v.eg0});
    end
    if (v.r0 && v.eg0) issue(1'b0, v.w0, v.a0, v.d0);
    else if (v.r1 && v.eg1) issue(1'b1, v.w1, v.a1, v.d1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic mon_rd(input int i);
    rd_exp_t e;
    logic have;
    have = 1'b0;
    e.id = 1'b0; e.data = '0; e.due = 0;
    case (i)
      0: if (q_rd0.size() > 0 && q_rd0[0].due == cyc) begin e = q_rd0.pop_front(); have = 1'b1; end
      1: if (q_rd1.size() > 0 && q_rd1[0].due == cyc) begin e = q_rd1.pop_front(); have = 1'b1; end
      default: if (q_rd2.size() > 0 && q_rd2[0].due == cyc) begin
        e = q_rd2.pop_front(); have = 1'b1;
      end
    endcase
    chk($sformatf("L%0d rvalid {m1,m0}", i + 1), {rv1[i], rv0[i]},
        have ? {e.id, ~e.id} : 2'b00);
    if (have) chk($sformatf("L%0d rdata", i + 1), e.id ? rd1[i] : rd0[i], e.data);
  endtask

  is_exp_t ie_m;
  always @(negedge clk_i) begin
    if (mon_en) begin
      for (int i = 0; i < int'(NI); i++) mon_rd(i);
      if (q_is.size() > 0 && q_is[0].due == cyc) begin
        ie_m = q_is.pop_front();
        chk("issue clken", s2_clken[1], 1'b1);
        chk("issue we", s2_we[1], ie_m.we);
        chk("issue addr", s2_addr[1], ie_m.addr);
        if (ie_m.we) chk("issue wdata", s2_wdata[1], ie_m.wdata);
      end else begin
        chk("idle clken/we", {s2_clken[1], s2_we[1]}, 2'b00);
      end
    end
  end

  task automatic chk_zero(input string nm);
    for (int i = 0; i < int'(NI); i++) begin
      chk({nm, " gnt/rvalid"}, {g1[i], g0[i], rv1[i], rv0[i]}, 4'b0);
    end
    chk({nm, " s2 ctl"}, {s2_clken[1], s2_we[1]}, 2'b00);
    chk({nm, " s2 addr"}, s2_addr[1], '0);
    chk({nm, " s2 wdata"}, s2_wdata[1], '0);
  endtask

  initial begin
    for (int a = 0; a < 16; a++) ref_mem[a] = 32'hC0DE_0000 + a;
    rst_n = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_lock = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_lock = 1'b0;

    // Fairness from reset, then a withdrawal that must leave round-robin alone
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 8, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 1, 0, 8, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 1, 0, 9, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 2, 0, 0, 1, 0, 9, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 2, 0, 0, 1, 0, 10, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 3, 0, 0, 1, 0, 10, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 4, 0, 0, 1, 0, 11, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 11, 0, 0, 0, 1));
    // Write then read the same address back to back
    vecs.push_back(mk(1, 1, 3, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 10, 32'h1234_5678, 0, 0, 1));
    // Lock sequence: read A, read B, write Y while m1 keeps requesting
`ifdef DPRAM_ARB_LOCK_EN
    vecs.push_back(mk(1, 0, 5, 0, 1, 1, 0, 9, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 6, 0, 1, 1, 0, 9, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 7, 32'hCAFE_F00D, 0, 1, 0, 9, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 9, 0, 0, 0, 1));
`else
    vecs.push_back(mk(1, 0, 5, 0, 1, 1, 0, 9, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 6, 0, 1, 1, 0, 9, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 6, 0, 1, 1, 0, 9, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 7, 32'hCAFE_F00D, 0, 1, 0, 9, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 7, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 0, 1, 0));
`endif

    // Reset state, with both requests high to show grants are held low
    repeat (3) @(posedge clk_i);
    #1;
    ram_ready = 1'b1;
    @(negedge clk_i);
    chk_zero("reset");
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk_i);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    foreach (vecs[i]) beat(vecs[i]);
    idle(6);

    // Latency sweep over all 16 addresses
    for (int i = 0; i < 16; i++) beat(mk(1, 1, 4'(i), 32'h5A5A_0000 | i, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 16; i++) beat(mk(0, 0, 0, 0, 0, 1, 0, 4'(i), 0, 0, 0, 1));
    idle(6);

    // Reset with two reads in flight
    beat(mk(1, 0, 2, 0, 0, 1, 0, 12, 0, 0, 1, 0));
    beat(mk(1, 0, 3, 0, 0, 1, 0, 12, 0, 0, 0, 1));
    rst_n = 1'b0;
    q_rd0.delete(); q_rd1.delete(); q_rd2.delete(); q_is.delete();
    #1;
    chk_zero("mid reset");
    repeat (2) @(posedge clk_i);
    #1;
    rst_n = 1'b1;
    beat(mk(1, 0, 3, 0, 0, 1, 0, 12, 0, 0, 1, 0));
    beat(mk(0, 0, 0, 0, 0, 1, 0, 12, 0, 0, 0, 1));
    idle(8);

    chk("queues drained", q_rd0.size() + q_rd1.size() + q_rd2.size() + q_is.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dpram_port_arbiter.md
# dpram_port_arbiter

Two-master arbiter for port s2 of the shared 16×32 dual-port RAM. The multiply sequencer (master 0) and the status/result writer (master 1) both reach port s2 through this block; the CPU side keeps port s1. It grants one access per cycle with round-robin fairness, registers the RAM control signals, and routes read-valid back to the issuing master through a fixed-latency tag pipeline. An optional lock lets a master keep port s2 for an indivisible read-A / read-B / write-Y sequence.

## Interface
- ADDR_W, 4, RAM word address width
- DATA_W, 32, RAM data width
- READ_LATENCY, 2, cycles from the address cycle on port s2 to valid readdata (legal values 1..3)

- clk_i  in  1  clock, all logic on the rising edge
- rst_i_n  in  1  reset, asynchronous, active-low
- mN_req_i  in  1  master N (N = 0, 1) request; fields are held stable until the grant is taken
- mN_we_i  in  1  master N: 1 = write, 0 = read
- mN_addr_i  in  ADDR_W  master N word address
- mN_wdata_i  in  DATA_W  master N write data
- mN_lock_i  in  1  master N keeps ownership after this beat
- mN_gnt_o  out  1  combinational grant; handshake = req & gnt at a rising edge
- mN_rvalid_o  out  1  single-cycle pulse when read data for master N is on mN_rdata_o
- mN_rdata_o  out  DATA_W  equals dpram_s2_readdata
- dpram_s2_addr_o  out  ADDR_W  registered address
- dpram_s2_clken_o  out  1  registered, high one cycle per access
- dpram_s2_write_en_o  out  1  registered write enable
- dpram_s2_writedata  out  DATA_W  registered write data
- dpram_s2_readdata  in  DATA_W  RAM read data

## Operation
- **Reset values:** all dpram_s2_* outputs are 0. All gnt and rvalid outputs are 0. The state is ARB_OPEN. last_grant = 1, so master 0 wins first. The tag pipeline is cleared.
- **States:**
  - ARB_OPEN: round-robin arbitration.
    - Only one master requesting: that master is granted.
    - Both requesting: the master that is not last_grant is granted.
  - ARB_LOCK0 / ARB_LOCK1: only the owner can be granted (gnt = owner req). The other master's gnt is forced to 0.
- **Transitions:**
  - ARB_OPEN → ARB_LOCKN on a handshake by master N with mN_lock_i = 1.
  - ARB_LOCKN → ARB_OPEN on an owner handshake with lock_i = 0. That beat is still issued.
  - Ownership never passes from one master to the other directly while a lock is held.
- **last_grant** updates on every handshake.
- **Throughput:** one handshake per cycle. The same master can take grants back to back when the other master is idle.
- **Issue:** on a handshake, the winner's addr, we and wdata are registered into the dpram_s2_* outputs with clken = 1 for one cycle. With no handshake, clken = 0 and write_en = 0; addr and writedata hold their previous values.
- **Read tags:** each read pushes {valid, master id} into a tag shift register READ_LATENCY+1 deep. Writes push valid = 0. At the pipe exit, rvalid pulses for the tagged master.
- **Request withdrawal:** a master may drop req without a grant. No access is issued, and round-robin state is unchanged.
- **Ordering:** a read issued the cycle after a write to the same address returns the new data.
- **Reset mid-operation:** reads in flight are discarded, no rvalid is produced for them, and any held lock is released.

## Timing
- Handshake in cycle n → dpram_s2_clken_o high in cycle n+1.
- For a read, dpram_s2_readdata is valid in cycle n+1+READ_LATENCY, and mN_rvalid_o is high in exactly that cycle.
- Read latency from the handshake is READ_LATENCY+1 cycles (3 at the default).
- Grant is combinational, with zero-cycle decision latency.
- At most one clken cycle and at most one rvalid pulse (on one master) per clock.

## Configuration
- Macro: DPRAM_ARB_LOCK_EN.
- **Defined:** ARB_LOCK0 and ARB_LOCK1 exist and behave as described in Operation.
- **Undefined:**
  - mN_lock_i ports remain present but are ignored.
  - The state machine reduces to ARB_OPEN only, and every handshake arbitrates round-robin.
  - Port list is identical in both builds.

## Test plan
- **Reset:** assert rst_i_n = 0 mid-stream with 2 reads in flight → all outputs 0 immediately, no rvalid afterwards, and the first post-reset contention grants m0.
- **Write then read:** m0 writes 0xDEADBEEF to addr 3, then reads addr 3 in the next cycle → m0_rvalid_o high 3 cycles after the read handshake, m0_rdata_o = 0xDEADBEEF, m1_rvalid_o stays 0.
- **Fairness:** both masters hold req with reads for 6 cycles → grants alternate m0, m1, m0, m1, m0, m1, and clken is high in 6 consecutive cycles.
- **Lock (DPRAM_ARB_LOCK_EN defined):** m0 issues read A (lock = 1), read B (lock = 1), write Y (lock = 0) while m1 requests continuously → m1_gnt_o = 0 for those 3 beats, and m1 is granted the following cycle.
- **Lock compiled out (DPRAM_ARB_LOCK_EN undefined):** same stimulus → grants interleave m0, m1, m0, m1 regardless of m0_lock_i.
- **Latency sweep:** READ_LATENCY = 1 and READ_LATENCY = 3 with a RAM model of matching latency → rvalid at handshake + 2 and handshake + 4 respectively, with correct data on 16 addresses (addresses 0..15).
